// File: rtl/pipe_stage_regs.sv
// ============================================================================
// pipe_stage_regs: IF/ID, ID/EX, EX/MEM, MEM/WB register bank with write-back
// decode and saturating bubble/flush debug counters.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_stage_regs #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      fetch_instr,
   input  logic [31:0]      fetch_pc4,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      id_rd0,
   input  logic [31:0]      id_rd1,
   input  logic [31:0]      id_imm,
   input  logic [31:0]      ex_alu_result,
   input  logic [31:0]      ex_store_data,
   input  logic [31:0]      mem_read_data,
   output logic [31:0]      instrIFID,
   output logic [31:0]      instrIDEX,
   output logic [31:0]      instrEXMEM,
   output logic [31:0]      instrMEMWB,
   output logic [31:0]      pcIFID,
   output logic [31:0]      idex_d0,
   output logic [31:0]      idex_d1,
   output logic [31:0]      idex_imm,
   output logic [31:0]      aluEXMEM_Data,
   output logic [31:0]      aluMEMWB_Data,
   output logic [31:0]      EXMEM_Data2Mem,
   output logic [31:0]      MEMWB_MemData,
   output logic             wb_we,
   output logic [4:0]       wb_addr,
   output logic [31:0]      wb_data,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [5:0] OP_REG  = 6'd0;
   localparam logic [5:0] OP_ADDI = 6'd8;
   localparam logic [5:0] OP_SLTI = 6'd10;
   localparam logic [5:0] OP_ANDI = 6'd12;
   localparam logic [5:0] OP_ORI  = 6'd13;
   localparam logic [5:0] OP_XORI = 6'd14;
   localparam logic [5:0] OP_SLLI = 6'd15;
   localparam logic [5:0] OP_LW   = 6'd35;

   localparam logic [5:0] FN_SLLV = 6'd4;
   localparam logic [5:0] FN_ADD  = 6'd32;
   localparam logic [5:0] FN_SUB  = 6'd34;
   localparam logic [5:0] FN_AND  = 6'd36;
   localparam logic [5:0] FN_OR   = 6'd37;
   localparam logic [5:0] FN_XOR  = 6'd38;
   localparam logic [5:0] FN_SLT  = 6'd42;

   logic [31:0]      instr_ifid_q,  instr_ifid_d;
   logic [31:0]      pc_ifid_q,     pc_ifid_d;
   logic [31:0]      instr_idex_q,  instr_idex_d;
   logic [31:0]      idex_d0_q,     idex_d0_d;
   logic [31:0]      idex_d1_q,     idex_d1_d;
   logic [31:0]      idex_imm_q,    idex_imm_d;
   logic [31:0]      instr_exmem_q, instr_exmem_d;
   logic [31:0]      alu_exmem_q,   alu_exmem_d;
   logic [31:0]      store_exmem_q, store_exmem_d;
   logic [31:0]      instr_memwb_q, instr_memwb_d;
   logic [31:0]      alu_memwb_q,   alu_memwb_d;
   logic [31:0]      mdata_memwb_q, mdata_memwb_d;
   logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;

   always_comb begin
      instr_ifid_d  = fetch_instr;
      pc_ifid_d     = fetch_pc4;
      instr_idex_d  = instr_ifid_q;
      idex_d0_d     = id_rd0;
      idex_d1_d     = id_rd1;
      idex_imm_d    = id_imm;
      instr_exmem_d = instr_idex_q;
      alu_exmem_d   = ex_alu_result;
      store_exmem_d = ex_store_data;
      instr_memwb_d = instr_exmem_q;
      alu_memwb_d   = alu_exmem_q;
      mdata_memwb_d = mem_read_data;
      bubble_cnt_d  = bubble_cnt_q;
      flush_cnt_d   = flush_cnt_q;

      // Stall outranks flush: the branch re-asserts flush once its operands arrive.
      if (stall) begin
         instr_ifid_d = instr_ifid_q;
         pc_ifid_d    = pc_ifid_q;
         instr_idex_d = NOP_INSTR;
         idex_d0_d    = '0;
         idex_d1_d    = '0;
         idex_imm_d   = '0;
         if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else if (flush) begin
         instr_ifid_d = NOP_INSTR;
         pc_ifid_d    = '0;
         if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_ifid_q  <= NOP_INSTR;
         pc_ifid_q     <= '0;
         instr_idex_q  <= NOP_INSTR;
         idex_d0_q     <= '0;
         idex_d1_q     <= '0;
         idex_imm_q    <= '0;
         instr_exmem_q <= NOP_INSTR;
         alu_exmem_q   <= '0;
         store_exmem_q <= '0;
         instr_memwb_q <= NOP_INSTR;
         alu_memwb_q   <= '0;
         mdata_memwb_q <= '0;
         bubble_cnt_q  <= '0;
         flush_cnt_q   <= '0;
      end else begin
         instr_ifid_q  <= instr_ifid_d;
         pc_ifid_q     <= pc_ifid_d;
         instr_idex_q  <= instr_idex_d;
         idex_d0_q     <= idex_d0_d;
         idex_d1_q     <= idex_d1_d;
         idex_imm_q    <= idex_imm_d;
         instr_exmem_q <= instr_exmem_d;
         alu_exmem_q   <= alu_exmem_d;
         store_exmem_q <= store_exmem_d;
         instr_memwb_q <= instr_memwb_d;
         alu_memwb_q   <= alu_memwb_d;
         mdata_memwb_q <= mdata_memwb_d;
         bubble_cnt_q  <= bubble_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   logic [5:0] wb_op;
   logic [5:0] wb_funct;
   logic       wb_is_imm;
   logic       wb_is_lw;
   logic       wb_is_reg;
   logic [4:0] wb_dest;
   logic       unused_memwb_fields;

   assign wb_op               = instr_memwb_q[31:26];
   assign wb_funct            = instr_memwb_q[5:0];
   assign unused_memwb_fields = ^{instr_memwb_q[25:21], instr_memwb_q[10:6]};

   always_comb begin
      wb_is_imm = wb_op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI};
      wb_is_lw  = (wb_op == OP_LW);
      wb_is_reg = (wb_op == OP_REG) &&
                  (wb_funct inside {FN_SLLV, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT});
      wb_dest   = 5'd0;
      if (wb_is_imm || wb_is_lw) wb_dest = instr_memwb_q[20:16];
      else if (wb_is_reg)        wb_dest = instr_memwb_q[15:11];
      // A write to $0 is architecturally a no-op, so suppress the strobe too.
      wb_we   = (wb_is_imm || wb_is_lw || wb_is_reg) && (wb_dest != 5'd0);
      wb_addr = wb_we ? wb_dest : 5'd0;
      wb_data = wb_is_lw ? mdata_memwb_q : alu_memwb_q;
   end

   assign instrIFID      = instr_ifid_q;
   assign instrIDEX      = instr_idex_q;
   assign instrEXMEM     = instr_exmem_q;
   assign instrMEMWB     = instr_memwb_q;
   assign pcIFID         = pc_ifid_q;
   assign idex_d0        = idex_d0_q;
   assign idex_d1        = idex_d1_q;
   assign idex_imm       = idex_imm_q;
   assign aluEXMEM_Data  = alu_exmem_q;
   assign aluMEMWB_Data  = alu_memwb_q;
   assign EXMEM_Data2Mem = store_exmem_q;
   assign MEMWB_MemData  = mdata_memwb_q;
   assign bubble_cnt     = bubble_cnt_q;
   assign flush_cnt      = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
// ============================================================================
// tb_pipe_stage_regs: directed bench with a write-back scoreboard for
// pipe_stage_regs, plus a narrow-counter instance for saturation.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_instr, fetch_pc4, id_rd0, id_rd1, id_imm;
   logic [31:0] ex_alu_result, ex_store_data, mem_read_data;
   logic        stall, flush, stall_s;

   logic [31:0] instrIFID, instrIDEX, instrEXMEM, instrMEMWB, pcIFID;
   logic [31:0] idex_d0, idex_d1, idex_imm, aluEXMEM_Data, aluMEMWB_Data;
   logic [31:0] EXMEM_Data2Mem, MEMWB_MemData, wb_data;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [15:0] bubble_cnt, flush_cnt;

   logic [31:0] s_ifid, s_idex, s_exmem, s_memwb, s_pc, s_d0, s_d1, s_imm;
   logic [31:0] s_alu_em, s_alu_mw, s_st, s_md, s_wb_data;
   logic        s_wb_we;
   logic [4:0]  s_wb_addr;
   logic [3:0]  s_bubble_cnt, s_flush_cnt;

   always #5 clk = ~clk;

   pipe_stage_regs u_dut (
      .clk(clk), .rst_n(rst_n), .fetch_instr(fetch_instr), .fetch_pc4(fetch_pc4),
      .stall(stall), .flush(flush), .id_rd0(id_rd0), .id_rd1(id_rd1), .id_imm(id_imm),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .mem_read_data(mem_read_data), .instrIFID(instrIFID), .instrIDEX(instrIDEX),
      .instrEXMEM(instrEXMEM), .instrMEMWB(instrMEMWB), .pcIFID(pcIFID),
      .idex_d0(idex_d0), .idex_d1(idex_d1), .idex_imm(idex_imm),
      .aluEXMEM_Data(aluEXMEM_Data), .aluMEMWB_Data(aluMEMWB_Data),
      .EXMEM_Data2Mem(EXMEM_Data2Mem), .MEMWB_MemData(MEMWB_MemData),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   pipe_stage_regs #(.CNT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .fetch_instr(fetch_instr), .fetch_pc4(fetch_pc4),
      .stall(stall_s), .flush(1'b0), .id_rd0(id_rd0), .id_rd1(id_rd1), .id_imm(id_imm),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .mem_read_data(mem_read_data), .instrIFID(s_ifid), .instrIDEX(s_idex),
      .instrEXMEM(s_exmem), .instrMEMWB(s_memwb), .pcIFID(s_pc),
      .idex_d0(s_d0), .idex_d1(s_d1), .idex_imm(s_imm),
      .aluEXMEM_Data(s_alu_em), .aluMEMWB_Data(s_alu_mw),
      .EXMEM_Data2Mem(s_st), .MEMWB_MemData(s_md),
      .wb_we(s_wb_we), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
      .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
   );

   typedef struct {
      int          due;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t     sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [31:0] last_pc;

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_wb(input int lat, input logic [31:0] instr, input logic we,
                            input logic [4:0] addr, input logic [31:0] data);
      wb_exp_t e;
      e.due = cyc + lat; e.instr = instr; e.we = we; e.addr = addr; e.data = data;
      sb.push_back(e);
   endtask

   task automatic step(input logic [31:0] fi, input logic [31:0] alu, input logic [31:0] md,
                       input logic st, input logic fl);
      wb_exp_t e;
      fetch_instr   = fi;
      last_pc       = 32'h0040_0000 + 32'(cyc * 4);
      fetch_pc4     = last_pc;
      id_rd0        = fi ^ 32'h1111_1111;
      id_rd1        = fi ^ 32'h2222_2222;
      id_imm        = fi ^ 32'h3333_3333;
      ex_alu_result = alu;
      ex_store_data = alu ^ 32'hFFFF_0000;
      mem_read_data = md;
      stall         = st;
      flush         = fl;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk("wb_instr", instrMEMWB, e.instr);
         chk("wb_we",    {31'd0, wb_we}, {31'd0, e.we});
         chk("wb_addr",  {27'd0, wb_addr}, {27'd0, e.addr});
         chk("wb_data",  wb_data, e.data);
      end
   endtask

   localparam logic [31:0] NOP = 32'h0000_0000;

   initial begin
      logic [31:0] addi5, lw3, add6, ori9, sub7, xor8, xor_fl, sw4, jr, add0;
      addi5  = itype(6'd8, 5'd0, 5'd5, 16'h0001);
      lw3    = itype(6'd35, 5'd1, 5'd3, 16'h0040);
      add6   = rtype(5'd3, 5'd4, 5'd6, 6'd32);
      ori9   = itype(6'd13, 5'd2, 5'd9, 16'h00F0);
      sub7   = rtype(5'd1, 5'd2, 5'd7, 6'd34);
      xor_fl = rtype(5'd1, 5'd2, 5'd10, 6'd38);
      xor8   = rtype(5'd1, 5'd2, 5'd8, 6'd38);
      sw4    = itype(6'd43, 5'd1, 5'd4, 16'h0008);
      jr     = rtype(5'd31, 5'd0, 5'd0, 6'd8);
      add0   = rtype(5'd1, 5'd2, 5'd0, 6'd32);

      rst_n = 1'b1; stall = 1'b0; flush = 1'b0; stall_s = 1'b0;
      fetch_instr = '0; fetch_pc4 = '0; id_rd0 = '0; id_rd1 = '0; id_imm = '0;
      ex_alu_result = '0; ex_store_data = '0; mem_read_data = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ifid", instrIFID, NOP);
      chk("rst_memwb", instrMEMWB, NOP);
      chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
      chk("rst_bubble", {16'd0, bubble_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADDI through the empty pipe
      expect_wb(4, addi5, 1'b1, 5'd5, 32'h0000_00A5);
      step(addi5, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("flow_ifid", instrIFID, addi5);
      chk("flow_pc", pcIFID, last_pc);
      step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'hA5, 32'h0, 1'b0, 1'b0);
      chk("alu_exmem", aluEXMEM_Data, 32'hA5);
      step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("alu_memwb", aluMEMWB_Data, 32'hA5);

      // LW / ADD load-use with one stall cycle
      expect_wb(4, lw3, 1'b1, 5'd3, 32'h7);
      step(lw3, 32'h0, 32'h0, 1'b0, 1'b0);
      expect_wb(5, add6, 1'b1, 5'd6, 32'h55);
      step(add6, 32'h0, 32'h0, 1'b0, 1'b0);
      step(ori9, 32'h40, 32'h0, 1'b1, 1'b0);
      chk("stall_ifid_hold", instrIFID, add6);
      chk("stall_idex_nop", instrIDEX, NOP);
      chk("stall_idex_d0", idex_d0, 32'h0);
      chk("stall_bubble", {16'd0, bubble_cnt}, 32'd1);
      expect_wb(4, ori9, 1'b1, 5'd9, 32'h99);
      step(ori9, 32'h0, 32'h7, 1'b0, 1'b0);
      chk("stall_idex_add", instrIDEX, add6);
      step(NOP, 32'h55, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h99, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);

      // Flush squashes only IF/ID
      expect_wb(4, sub7, 1'b1, 5'd7, 32'h33);
      step(sub7, 32'h0, 32'h0, 1'b0, 1'b0);
      step(xor_fl, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("flush_ifid", instrIFID, NOP);
      chk("flush_pc", pcIFID, 32'h0);
      chk("flush_idex", instrIDEX, sub7);
      chk("flush_cnt", {16'd0, flush_cnt}, 32'd1);
      step(NOP, 32'h33, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);

      // Stall and flush together: stall wins
      expect_wb(5, xor8, 1'b1, 5'd8, 32'h88);
      step(xor8, 32'h0, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h0, 32'h0, 1'b1, 1'b1);
      chk("prio_ifid", instrIFID, xor8);
      chk("prio_idex", instrIDEX, NOP);
      chk("prio_bubble", {16'd0, bubble_cnt}, 32'd2);
      chk("prio_flush", {16'd0, flush_cnt}, 32'd1);
      step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h88, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);

      // Non-writers: SW, JR, ADD to $0
      expect_wb(4, sw4, 1'b0, 5'd0, 32'h11);
      step(sw4, 32'h0, 32'h0, 1'b0, 1'b0);
      expect_wb(4, jr, 1'b0, 5'd0, 32'h22);
      step(jr, 32'h0, 32'h0, 1'b0, 1'b0);
      expect_wb(4, add0, 1'b0, 5'd0, 32'h44);
      step(add0, 32'h11, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h22, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h44, 32'h0, 1'b0, 1'b0);
      step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);

      // 4-bit counter saturation on the narrow instance
      stall_s = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
         if (i == 13) chk("sat_cnt14", {28'd0, s_bubble_cnt}, 32'hE);
      end
      stall_s = 1'b0;
      chk("sat_cnt20", {28'd0, s_bubble_cnt}, 32'hF);
      chk("main_bubble_kept", {16'd0, bubble_cnt}, 32'd2);

      // Asynchronous reset with writers in flight
      for (int i = 0; i < 4; i++) step(addi5, 32'hA5, 32'h0, 1'b0, 1'b0);
      chk("pre_rst_we", {31'd0, wb_we}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ifid", instrIFID, NOP);
      chk("mid_rst_idex", instrIDEX, NOP);
      chk("mid_rst_exmem", instrEXMEM, NOP);
      chk("mid_rst_memwb", instrMEMWB, NOP);
      chk("mid_rst_we", {31'd0, wb_we}, 32'd0);
      chk("mid_rst_data", wb_data, 32'd0);
      chk("mid_rst_bubble", {16'd0, bubble_cnt}, 32'd0);
      chk("mid_rst_flush", {16'd0, flush_cnt}, 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
